// File: rtl/decoder38_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decoder38_pipe
// Description : 3-to-8 one-hot decoder behind a 2-entry valid/ready FIFO,
//               with a wrapping count of delivered words.
//               Optional build macro DECODER38_PARITY_EN adds an even-parity
//               check on the input code (ports in_par / perr).
// Revision    : 1.0 - initial release
// ============================================================================
module decoder38_pipe #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       A,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] dec_cnt
`ifdef DECODER38_PARITY_EN
    ,
    input  logic             in_par,
    output logic             perr
`endif
);

    // Buffer occupancy encoding
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [2:0]       r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_y;

    // Ready depends only on enable, reset and occupancy; never on out_ready
    assign in_ready  = en && !rst && (r_state != c_FULL);
    assign out_valid = (r_state != c_EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

`ifdef DECODER38_PARITY_EN
    logic r_perr;
    logic w_par_bad;

    // A word with bad parity still completes its handshake but is dropped
    assign w_par_bad = (in_par != ^A);
    assign w_push    = w_accept && !w_par_bad;
    assign perr      = r_perr;

    // Sticky parity-error flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else if (w_accept && w_par_bad) begin
            r_perr <= 1'b1;
        end
    end
`else
    assign w_push = w_accept;
`endif

    // Occupancy next-state: push increments, pop decrements, both hold
    always_comb begin
        w_state_nxt = r_state;
        case ({w_push, w_pop})
            2'b10: begin
                if (r_state == c_EMPTY) w_state_nxt = c_ONE;
                else                    w_state_nxt = c_FULL;
            end
            2'b01: begin
                if (r_state == c_FULL) w_state_nxt = c_ONE;
                else                   w_state_nxt = c_EMPTY;
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // Occupancy state and FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_EMPTY;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
        end
    end

    // Storage for accepted codes; contents are don't-care while not occupied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= 3'd0;
            r_mem[1] <= 3'd0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= A;
        end
    end

    // Delivered-word counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // One-hot decode of the head entry, forced to zero when nothing is held
    always_comb begin
        w_y = 8'h00;
        if (out_valid) begin
            w_y[r_mem[r_rd_ptr]] = 1'b1;
        end
    end

    assign Y       = w_y;
    assign dec_cnt = r_cnt;

endmodule
`default_nettype wire
